// File: rtl/nn_display_pkg.sv
// rtl/nn_display_pkg.sv - shared digit constants and capture FSM encoding for the NN display path
package nn_display_pkg;

  localparam int              DIGIT_W     = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hF;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX   = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/gpio_digit_capture_if.sv
// rtl/gpio_digit_capture_if.sv - GPIO pins from the NN processor and the held digit toward the display
interface gpio_digit_capture_if;
  import nn_display_pkg::*;

  logic [DIGIT_W-1:0] gpio_raw;
  logic               gpio_strobe;
  logic [DIGIT_W-1:0] gpio_digit;
  logic               digit_valid;
  logic               new_digit;
  logic               err_invalid;

  modport master (
    output gpio_raw, gpio_strobe,
    input  gpio_digit, digit_valid, new_digit, err_invalid
  );

  modport slave (
    input  gpio_raw, gpio_strobe,
    output gpio_digit, digit_valid, new_digit, err_invalid
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - W-bit two-stage synchronizer with asynchronous active-low reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_digit_capture.sv
// rtl/gpio_digit_capture.sv - synchronize, stability-filter and range-check the NN digit, with blanking timeout
module gpio_digit_capture
  import nn_display_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gpio_digit_capture_if.slave  cap
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic [DIGIT_W-1:0] sync_raw;
  logic               sync_strobe;

  sync_2ff #(.W(DIGIT_W + 1)) u_sync (
    .clk   (clk),
    .rst_n (rst_int_n),
    .d_i   ({cap.gpio_strobe, cap.gpio_raw}),
    .q_o   ({sync_strobe, sync_raw})
  );

  // prime_q masks edge detection until the sync chain holds real pin state,
  // so a strobe already high through reset is not mistaken for a new result.
  logic       strobe_d_q;
  logic [2:0] prime_q;
  logic       rise_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      strobe_d_q <= 1'b0;
      prime_q    <= 3'b000;
      rise_q     <= 1'b0;
    end else begin
      strobe_d_q <= sync_strobe;
      prime_q    <= {prime_q[1:0], 1'b1};
      rise_q     <= sync_strobe & ~strobe_d_q & prime_q[2];
    end
  end

  cap_state_e          state_q, state_d;
  logic [DIGIT_W-1:0]  ref_q, ref_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic                valid_q, valid_d;
  logic                new_q, new_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      ref_q   <= '0;
      stab_q  <= '0;
      tmo_q   <= '0;
      digit_q <= DIGIT_BLANK;
      valid_q <= 1'b0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      new_q   <= new_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    digit_d = digit_q;
    valid_d = valid_q;
    new_d   = 1'b0;
    err_d   = 1'b0;

    if (valid_q) begin
      if (tmo_q == TMO_LAST) begin
        digit_d = DIGIT_BLANK;
        valid_d = 1'b0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (rise_q) begin
          ref_d   = sync_raw;
          stab_d  = STAB_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (rise_q || (sync_raw != ref_q)) begin
          ref_d  = sync_raw;
          stab_d = STAB_ONE;
        end else if (stab_q == STAB_DONE) begin
          state_d = DECIDE;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end
      DECIDE: begin
        state_d = IDLE;
        // Acceptance overrides a timeout landing in the same cycle.
        if (ref_q <= DIGIT_MAX) begin
          digit_d = ref_q;
          valid_d = 1'b1;
          new_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap.gpio_digit  = digit_q;
  assign cap.digit_valid = valid_q;
  assign cap.new_digit   = new_q;
  assign cap.err_invalid = err_q;

endmodule

// File: tb/tb_gpio_digit_capture.sv
// tb/tb_gpio_digit_capture.sv - scoreboard bench for gpio_digit_capture
module tb_gpio_digit_capture;
  import nn_display_pkg::*;

  localparam int STABLE = 4;
  localparam int TMO    = 200;

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  gpio_digit_capture_if bus();

  gpio_digit_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cap   (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   cyc         = 0;
  int   last_nd_cyc = -1;
  int   nd_count    = 0;
  int   err_count   = 0;
  bit   saw3        = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Every pulse must match the next expected event: kind and the digit held alongside it.
  always @(negedge clk) begin
    if (bus.gpio_digit == 4'h3) saw3 = 1'b1;
    if (bus.new_digit === 1'b1) begin
      nd_count++;
      last_nd_cyc = cyc;
    end
    if (bus.err_invalid === 1'b1) err_count++;
    if (bus.new_digit === 1'b1 || bus.err_invalid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_pulse: new_digit=%0b err_invalid=%0b digit=%h, required no pulse",
                 bus.new_digit, bus.err_invalid, bus.gpio_digit);
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus.new_digit, bus.err_invalid, bus.gpio_digit} !== {~mon_e.err, mon_e.err, mon_e.digit})
          $display("FAIL scoreboard: new=%0b err=%0b digit=%h, required new=%0b err=%0b digit=%h",
                   bus.new_digit, bus.err_invalid, bus.gpio_digit, ~mon_e.err, mon_e.err, mon_e.digit);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input string name, input int budget);
    int i = 0;
    while (sb_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      $display("FAIL %s_wait: %0d results pending after %0d cycles, required 0", name, sb_q.size(), budget);
      sb_q.delete();
    end else n_pass++;
  endtask

  task automatic strobe_digit(input logic [3:0] raw, input logic err, input logic [3:0] held);
    bus.gpio_raw    = raw;
    bus.gpio_strobe = 1'b1;
    sb_q.push_back(exp_t'{err, held});
  endtask

  task automatic test_reset;
    bit bad = 1'b0;
    rst_n = 1'b0;
    bus.gpio_raw = 4'h7;
    bus.gpio_strobe = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.gpio_digit !== DIGIT_BLANK) $display("FAIL rst_digit: got %h required %h", bus.gpio_digit, DIGIT_BLANK); else n_pass++;
    n_checks++; if (bus.digit_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", bus.digit_valid); else n_pass++;
    n_checks++; if (bus.new_digit !== 1'b0) $display("FAIL rst_new: got %b required 0", bus.new_digit); else n_pass++;
    n_checks++; if (bus.err_invalid !== 1'b0) $display("FAIL rst_err: got %b required 0", bus.err_invalid); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.gpio_digit !== DIGIT_BLANK || bus.digit_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL rst_release_hold: digit=%h valid=%b, required F/0", bus.gpio_digit, bus.digit_valid); else n_pass++;
    bus.gpio_strobe = 1'b0;
    tick(3);
  endtask

  task automatic test_accept;
    int s_cyc, n0;
    tick(1);
    n0 = nd_count;
    s_cyc = cyc;
    strobe_digit(4'h5, 1'b0, 4'h5);
    wait_sb("accept", 30);
    // Pins settle before edge s_cyc+1; new_digit follows 8 edges later.
    n_checks++; if (last_nd_cyc !== s_cyc + 1 + 8) $display("FAIL accept_latency: got edge %0d required %0d", last_nd_cyc, s_cyc + 9); else n_pass++;
    tick(3);
    n_checks++; if (nd_count - n0 !== 1) $display("FAIL accept_pulse_width: got %0d cycles required 1", nd_count - n0); else n_pass++;
    n_checks++; if (bus.gpio_digit !== 4'h5) $display("FAIL accept_digit: got %h required 5", bus.gpio_digit); else n_pass++;
    n_checks++; if (bus.digit_valid !== 1'b1) $display("FAIL accept_valid: got %b required 1", bus.digit_valid); else n_pass++;
    bus.gpio_strobe = 1'b0;
    tick(3);
  endtask

  task automatic test_invalid;
    int n0, e0;
    n0 = nd_count;
    e0 = err_count;
    strobe_digit(4'hC, 1'b1, 4'h5);
    wait_sb("invalid", 30);
    tick(3);
    n_checks++; if (err_count - e0 !== 1) $display("FAIL invalid_err_pulse: got %0d required 1", err_count - e0); else n_pass++;
    n_checks++; if (nd_count !== n0) $display("FAIL invalid_no_new: got %0d pulses required 0", nd_count - n0); else n_pass++;
    n_checks++; if (bus.gpio_digit !== 4'h5) $display("FAIL invalid_hold: got %h required 5", bus.gpio_digit); else n_pass++;
    n_checks++; if (bus.digit_valid !== 1'b1) $display("FAIL invalid_valid: got %b required 1", bus.digit_valid); else n_pass++;
    bus.gpio_strobe = 1'b0;
    tick(3);
  endtask

  task automatic test_bounce;
    strobe_digit(4'h3, 1'b0, 4'h8);
    tick(3);
    bus.gpio_raw = 4'h8;
    wait_sb("bounce", 40);
    n_checks++; if (bus.gpio_digit !== 4'h8) $display("FAIL bounce_digit: got %h required 8", bus.gpio_digit); else n_pass++;
    n_checks++; if (saw3) $display("FAIL bounce_glitch: digit 3 appeared=%0b required 0", saw3); else n_pass++;
    bus.gpio_strobe = 1'b0;
    tick(3);
  endtask

  task automatic measure_blank(input string name, input int a);
    int blank = -1;
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clk);
      if (bus.digit_valid !== 1'b1) begin
        blank = cyc;
        break;
      end
    end
    n_checks++; if (blank - a !== TMO) $display("FAIL %s_cycle: blank after %0d cycles required %0d", name, blank - a, TMO); else n_pass++;
    n_checks++; if (bus.gpio_digit !== DIGIT_BLANK) $display("FAIL %s_digit: got %h required F", name, bus.gpio_digit); else n_pass++;
  endtask

  task automatic test_timeout;
    tick(1);
    strobe_digit(4'h2, 1'b0, 4'h2);
    wait_sb("tmo_first", 30);
    bus.gpio_strobe = 1'b0;
    measure_blank("tmo_blank", last_nd_cyc);
    tick(1);
    strobe_digit(4'h2, 1'b0, 4'h2);
    wait_sb("tmo_restrobe", 30);
    n_checks++; if ({bus.digit_valid, bus.gpio_digit} !== {1'b1, 4'h2}) $display("FAIL tmo_redisplay: valid=%b digit=%h required 1/2", bus.digit_valid, bus.gpio_digit); else n_pass++;
    bus.gpio_strobe = 1'b0;
    tick(150);
    // Same digit again: must still pulse and restart the blanking interval.
    strobe_digit(4'h2, 1'b0, 4'h2);
    wait_sb("tmo_repeat", 30);
    bus.gpio_strobe = 1'b0;
    measure_blank("tmo_reload", last_nd_cyc);
  endtask

  task automatic test_reset_mid_settle;
    bit bad = 1'b0;
    tick(1);
    strobe_digit(4'h4, 1'b0, 4'h4);
    wait_sb("pre_reset", 30);
    bus.gpio_strobe = 1'b0;
    tick(4);
    strobe_digit(4'h9, 1'b0, 4'h9);
    sb_q.delete();
    tick(5);
    #4 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.gpio_digit !== DIGIT_BLANK) $display("FAIL midrst_digit: got %h required F", bus.gpio_digit); else n_pass++;
    n_checks++; if (bus.digit_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", bus.digit_valid); else n_pass++;
    n_checks++; if ({bus.new_digit, bus.err_invalid} !== 2'b00) $display("FAIL midrst_pulses: got %b required 00", {bus.new_digit, bus.err_invalid}); else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.gpio_digit !== DIGIT_BLANK || bus.digit_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL midrst_release: digit=%h valid=%b required F/0", bus.gpio_digit, bus.digit_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_accept();
    test_invalid();
    test_bounce();
    test_timeout();
    test_reset_mid_settle();
    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
